// File: rtl/src_operand_stage.sv
// ALU src1 operand stage: selects register/forwarded data or an extended immediate,
// holds it in a one-entry valid/ready register and counts back-pressure cycles.
module src_operand_stage #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int OFF_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [1:0]        src_mode,
  input  logic              fwd_ex_en,
  input  logic [DATA_W-1:0] fwd_ex_data,
  input  logic              fwd_mem_en,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src_out,
  output logic              src_is_imm,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_vld;
  logic [DATA_W-1:0] r_src;
  logic              r_is_imm;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic [DATA_W-1:0] w_operand;

  assign in_ready = !r_vld | out_ready;
  assign w_accept = in_valid & in_ready & !flush;

  // Signed size casts give the sign extension without zero-width replications.
  always_comb begin
    w_operand = '0;
    case (src_mode)
      2'b00:   w_operand = fwd_ex_en  ? fwd_ex_data  :
                           fwd_mem_en ? fwd_mem_data : reg_data;
      2'b01:   w_operand = DATA_W'($signed(imm));
      2'b10:   w_operand = DATA_W'($signed(imm[OFF_W-1:0]));
      default: w_operand = DATA_W'(imm);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= 1'b0;
      r_src    <= '0;
      r_is_imm <= 1'b0;
    end else if (flush) begin
      r_vld    <= 1'b0;
    end else if (w_accept) begin
      r_vld    <= 1'b1;
      r_src    <= w_operand;
      r_is_imm <= (src_mode != 2'b00);
    end else if (out_ready) begin
      r_vld    <= 1'b0;
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_vld && !out_ready && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign out_valid  = r_vld;
  assign src_out    = r_src;
  assign src_is_imm = r_is_imm;
  assign stall_cnt  = r_cnt;

endmodule

// File: tb/tb_src_operand_stage.sv
// Bench for src_operand_stage: directed cases plus random traffic against a
// cycle-level reference model; a second instance checks narrow counter saturation.
module tb_src_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  imm;
  logic [15:0] reg_data;
  logic [1:0]  src_mode;
  logic        fwd_ex_en;
  logic [15:0] fwd_ex_data;
  logic        fwd_mem_en;
  logic [15:0] fwd_mem_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [15:0] src_out,   src_out2;
  logic        src_is_imm, src_is_imm2;
  logic [7:0]  stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  bit          m_vld;
  logic [15:0] m_val;
  bit          m_imm;
  int          m_stalls;

  src_operand_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .reg_data(reg_data), .src_mode(src_mode),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_data(fwd_mem_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .src_out(src_out), .src_is_imm(src_is_imm), .stall_cnt(stall_cnt)
  );

  src_operand_stage #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .imm(imm), .reg_data(reg_data), .src_mode(src_mode),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_data(fwd_mem_data),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .src_out(src_out2), .src_is_imm(src_is_imm2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_operand(input logic [1:0] md, input logic [7:0] im,
                                              input logic [15:0] rd, input bit fe,
                                              input logic [15:0] fed, input bit fm,
                                              input logic [15:0] fmd);
    int v;
    case (md)
      2'd0: return fe ? fed : (fm ? fmd : rd);
      2'd1: begin v = im;        if (v >= 128) v -= 256; return 16'(v); end
      2'd2: begin v = im % 16;   if (v >= 8)   v -= 16;  return 16'(v); end
      default: return 16'(im);
    endcase
  endfunction

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_val = '0; m_imm = 0; m_stalls = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_vld"},   32'(out_valid),  32'(m_vld));
    chk({tag, "_src"},   32'(src_out),    32'(m_val));
    chk({tag, "_isimm"}, 32'(src_is_imm), 32'(m_imm));
    chk({tag, "_cnt"},   32'(stall_cnt),  32'(sat(m_stalls, 8)));
    chk({tag, "_cnt2"},  32'(stall_cnt2), 32'(sat(m_stalls, 2)));
  endtask

  // One cycle: drive after negedge, advance the model at posedge, check at next negedge.
  task automatic step(input bit v, input logic [7:0] im, input logic [15:0] rd,
                      input logic [1:0] md, input bit fe, input logic [15:0] fed,
                      input bit fm, input logic [15:0] fmd, input bit fl, input bit rdy,
                      input string tag);
    bit acc;
    in_valid = v; imm = im; reg_data = rd; src_mode = md;
    fwd_ex_en = fe; fwd_ex_data = fed; fwd_mem_en = fm; fwd_mem_data = fmd;
    flush = fl; out_ready = rdy;
    #1;
    chk({tag, "_inrdy"}, 32'(in_ready), 32'(!m_vld || rdy));
    @(posedge clk);
    if (m_vld && !rdy) m_stalls++;
    acc = v && (!m_vld || rdy) && !fl;
    if (fl) m_vld = 0;
    else if (acc) begin
      m_vld = 1;
      m_val = ref_operand(md, im, rd, fe, fed, fm, fmd);
      m_imm = (md != 2'd0);
    end else if (rdy) m_vld = 0;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input bit rdy, input string tag);
    step(0, 8'h00, 16'h0, 2'd0, 0, 16'h0, 0, 16'h0, 0, rdy, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; imm = '0; reg_data = '0; src_mode = '0;
    fwd_ex_en = 0; fwd_ex_data = '0; fwd_mem_en = 0; fwd_mem_data = '0;
    flush = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // immediates
    step(1, 8'h80, 16'h0, 2'd1, 1, 16'h5555, 0, 16'h0, 0, 1, "t1a");
    chk("t1_sext80", 32'(src_out), 32'hFF80);
    chk("t1_isimm", 32'(src_is_imm), 32'd1);
    step(1, 8'h7F, 16'h0, 2'd1, 0, 16'h0, 0, 16'h0, 0, 1, "t1b");
    chk("t1_sext7f", 32'(src_out), 32'h007F);
    step(1, 8'hF8, 16'h0, 2'd2, 0, 16'h0, 0, 16'h0, 0, 1, "t2a");
    chk("t2_offF8", 32'(src_out), 32'hFFF8);
    step(1, 8'h07, 16'h0, 2'd2, 0, 16'h0, 1, 16'h9999, 0, 1, "t2b");
    chk("t2_off07", 32'(src_out), 32'h0007);
    step(1, 8'h80, 16'h0, 2'd3, 0, 16'h0, 0, 16'h0, 0, 1, "t2c");
    chk("t2_zext80", 32'(src_out), 32'h0080);

    // forwarding priority
    step(1, 8'h00, 16'h1111, 2'd0, 1, 16'h3333, 1, 16'h2222, 0, 1, "t3a");
    chk("t3_ex", 32'(src_out), 32'h3333);
    step(1, 8'h00, 16'h1111, 2'd0, 0, 16'h3333, 1, 16'h2222, 0, 1, "t3b");
    chk("t3_mem", 32'(src_out), 32'h2222);
    step(1, 8'h00, 16'h1111, 2'd0, 0, 16'h3333, 0, 16'h2222, 0, 1, "t3c");
    chk("t3_reg", 32'(src_out), 32'h1111);
    chk("t3_isimm", 32'(src_is_imm), 32'd0);

    // back-pressure: new requests offered while held must be refused
    step(1, 8'h00, 16'hABCD, 2'd0, 0, 16'h0, 0, 16'h0, 0, 1, "t4ld");
    for (int i = 0; i < 5; i++)
      step(1, 8'h12, 16'h5A5A, 2'd1, 0, 16'h0, 0, 16'h0, 0, 0, "t4st");
    chk("t4_hold", 32'(src_out), 32'hABCD);
    chk("t4_cnt5", 32'(stall_cnt), 32'd5);
    chk("t4_cnt2sat", 32'(stall_cnt2), 32'd3);

    // flush while holding, with a simultaneous request
    step(1, 8'h44, 16'h7777, 2'd0, 0, 16'h0, 0, 16'h0, 1, 0, "t5fl");
    chk("t5_flvld", 32'(out_valid), 32'd0);
    chk("t5_flkeep", 32'(src_out), 32'hABCD);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h00, 16'(16'h0100 + i), 2'd0, 0, 16'h0, 0, 16'h0, 0, 1, "t5b2b");
      chk("t5_order", 32'(src_out), 32'(16'h0100 + i));
    end
    idle(1, "t5drain");

    // asynchronous reset in the middle of a held transfer
    step(1, 8'h00, 16'hBEEF, 2'd0, 0, 16'h0, 0, 16'h0, 0, 1, "t6ld");
    idle(0, "t6st");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", 32'(out_valid), 32'd0);
    chk("t6_src", 32'(src_out), 32'd0);
    chk("t6_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("t6post");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom), 2'($urandom),
           $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
